dmem_bridge: RTL
================

# dmem_bridge

Memory-stage data-memory bridge sitting directly downstream of the pipelined datapath's M stage. It turns the single-cycle M-stage load/store request into a request/grant/response transaction toward a variable-latency data memory. It returns load data as `ReadDataM` and holds the pipeline with `stallMem` until each access completes. An optional one-entry posted-write buffer lets stores retire without stalling.

## Interface
Parameters:
- `AW`, 32, address width
- `DW`, 32, data width (byte lanes = DW/8 = 4)

Ports:
- `clk`  in  1  pipeline clock
- `reset`  in  1  asynchronous, active-high reset
- `MemReadM`  in  1  M-stage instruction is a load
- `MemWriteM`  in  1  M-stage instruction is a store
- `ALUResultM`  in  AW  byte address
- `WriteDataM`  in  DW  store data, already lane-aligned
- `byteEnable`  in  4  store/load lane mask
- `ReadDataM`  out  DW  load word to the W pipeline register
- `stallMem`  out  1  freezes F/D/E/M registers while high
- `mem_req`  out  1  request valid
- `mem_we`  out  1  1 = write
- `mem_addr`  out  AW  word address `{ALUResultM[AW-1:2],2'b00}`
- `mem_wdata`  out  DW  write data
- `mem_be`  out  4  lane mask
- `mem_gnt`  in  1  request accepted this cycle
- `mem_rvalid`  in  1  read data valid
- `mem_rdata`  in  DW  read data

## Operation
- States: IDLE, REQ, RESP, DONE.
- IDLE + (MemReadM | MemWriteM): drive `mem_req`=1 and all request fields combinationally.
  - `mem_gnt`=1: a store goes to DONE; a load goes to RESP.
  - `mem_gnt`=0: go to REQ.
- REQ: hold `mem_req` and fields, registered from the issue cycle.
  - `mem_gnt`=1: store goes to DONE, load goes to RESP.
- RESP: wait for `mem_rvalid`. On `mem_rvalid`, capture `mem_rdata` into `rdata_q` and go to DONE.
- DONE: access is retired. `stallMem`=0 and the pipeline advances at the clock edge. Next state is IDLE unconditionally.
- `stallMem` = (MemReadM | MemWriteM) & (state != DONE), combinational.
- `ReadDataM` = `rdata_q`, held until the next load capture.
- MemReadM and MemWriteM both high is illegal. The write takes priority.
- `mem_rvalid` outside RESP is ignored.
- `mem_gnt` while `mem_req`=0 is ignored.
- Request fields must stay stable from first assertion of `mem_req` until the grant.
- Reset values: state=IDLE, `rdata_q`=0, `ReadDataM`=0, `stallMem`=0, `mem_req`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `mem_be`=0.
- Reset mid-transaction abandons the access. The memory is reset by the same `reset`.

## Timing
- Store with immediate grant: issue in cycle 0 with `stallMem`=1; DONE in cycle 1 with `stallMem`=0. Cost is 1 stall cycle.
- Load, grant in cycle g, rvalid in cycle r (r ≥ g+1): DONE in cycle r+1, with `ReadDataM` valid in that cycle. Stall cycles = r+1.
- Back-to-back accesses: the next access issues in the cycle after DONE. There are no bubble requests.
- No combinational path from `mem_rdata` to `ReadDataM`.
- A combinational path from `MemReadM`/`MemWriteM` to `stallMem` and `mem_req` is allowed.

## Configuration
- Macro: `DMEM_BRIDGE_STORE_BUF_EN`.
- Defined: the block has a one-entry posted-write buffer.
  - A store in IDLE with the buffer empty is captured (addr/data/be) and retires that same cycle with `stallMem`=0.
  - The buffer drains autonomously via `mem_req`/`mem_we`=1.
  - A load or store arriving while the buffer is full stalls until the drain is granted, then proceeds normally. Loads never bypass or forward from the buffer.
  - Reset empties the buffer.
- Undefined: every store takes the REQ/DONE path described above, and the buffer logic is absent.

## Structure
- Package `dmem_pkg`: state enum `dmem_state_t` {IDLE, REQ, RESP, DONE}, constant `DMEM_LANES`=4, and function `word_align(addr)`.
- Sub-module `dmem_store_buf`, instantiated only under `DMEM_BRIDGE_STORE_BUF_EN`: full flag, entry registers, and drain request.

## Test plan
- Reset mid-RESP (load outstanding) → all outputs 0, state IDLE, a subsequent rvalid ignored, next load completes normally.
- Store addr 0x1006, data 0xAABBCCDD, be 4'b1100, gnt in same cycle → `mem_addr`=0x1004, `mem_we`=1, `mem_be`=4'b1100, `stallMem` high 1 cycle.
- Load addr 0x2000, gnt delayed 3 cycles, rvalid 2 cycles after gnt with 0x12345678 → `stallMem` high 6 cycles, then `ReadDataM`=0x12345678 in DONE.
- Store then load back-to-back, both immediate gnt, rvalid +1 → requests in consecutive non-DONE cycles, write granted before load, no request during DONE.
- With `DMEM_BRIDGE_STORE_BUF_EN`: store with gnt withheld 4 cycles → `stallMem`=0 on the store. A following load stalls until the drain is granted, then issues.
- MemReadM=MemWriteM=1 at addr 0x30 → `mem_we`=1, treated as a store, no RESP state entered.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types, constants and helpers for the data-memory bridge and its
// optional posted-write buffer.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2,
    DONE = 2'd3
  } dmem_state_t;

  localparam int DMEM_LANES  = 4;
  localparam int DMEM_MAX_AW = 64;

  // Callers cast their address in and out of the widest supported width.
  function automatic logic [DMEM_MAX_AW-1:0] word_align(input logic [DMEM_MAX_AW-1:0] addr);
    return addr & ~DMEM_MAX_AW'(3);
  endfunction

endpackage

// File: rtl/dmem_store_buf.sv
// One-entry posted-write buffer: holds a retired store until the memory
// grants its drain request.
module dmem_store_buf
  import dmem_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  capture_i,
  input  logic [AW-1:0]         addr_i,
  input  logic [DW-1:0]         wdata_i,
  input  logic [DMEM_LANES-1:0] be_i,
  input  logic                  gnt_i,
  output logic                  full_o,
  output logic                  drain_req_o,
  output logic [AW-1:0]         addr_o,
  output logic [DW-1:0]         wdata_o,
  output logic [DMEM_LANES-1:0] be_o
);

  logic                  full_q, full_d;
  logic [AW-1:0]         addr_q, addr_d;
  logic [DW-1:0]         wdata_q, wdata_d;
  logic [DMEM_LANES-1:0] be_q, be_d;

  always_comb begin
    full_d  = full_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    if (full_q && gnt_i) begin
      full_d = 1'b0;
    end
    if (capture_i) begin
      full_d  = 1'b1;
      addr_d  = addr_i;
      wdata_d = wdata_i;
      be_d    = be_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      full_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
    end else begin
      full_q  <= full_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
    end
  end

  assign full_o      = full_q;
  assign drain_req_o = full_q;
  assign addr_o      = addr_q;
  assign wdata_o     = wdata_q;
  assign be_o        = be_q;

endmodule

// File: rtl/dmem_bridge.sv
// M-stage to data-memory request/grant/response bridge with pipeline stall.
// Define DMEM_BRIDGE_STORE_BUF_EN to add the one-entry posted-write buffer.
module dmem_bridge
  import dmem_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  MemReadM,
  input  logic                  MemWriteM,
  input  logic [AW-1:0]         ALUResultM,
  input  logic [DW-1:0]         WriteDataM,
  input  logic [DMEM_LANES-1:0] byteEnable,
  output logic [DW-1:0]         ReadDataM,
  output logic                  stallMem,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [AW-1:0]         mem_addr,
  output logic [DW-1:0]         mem_wdata,
  output logic [DMEM_LANES-1:0] mem_be,
  input  logic                  mem_gnt,
  input  logic                  mem_rvalid,
  input  logic [DW-1:0]         mem_rdata
);

  dmem_state_t           state_q, state_d;
  logic                  we_q, we_d;
  logic [AW-1:0]         addr_q, addr_d;
  logic [DW-1:0]         wdata_q, wdata_d;
  logic [DMEM_LANES-1:0] be_q, be_d;
  logic [DW-1:0]         rdata_q, rdata_d;

  logic                  access;
  logic                  issue;
  logic [AW-1:0]         issueAddr;
  logic                  bufFull;
  logic                  bufDrain;
  logic                  bufCapture;
  logic [AW-1:0]         bufAddr;
  logic [DW-1:0]         bufWdata;
  logic [DMEM_LANES-1:0] bufBe;

  assign access    = MemReadM | MemWriteM;
  assign issueAddr = AW'(word_align(DMEM_MAX_AW'(ALUResultM)));

`ifdef DMEM_BRIDGE_STORE_BUF_EN
  logic bufDrainReq;

  // The buffer only ever fills from IDLE and nothing issues while it is full,
  // so its drain owns the bus whenever it is occupied.
  assign bufCapture = (state_q == IDLE) && MemWriteM && !bufFull;
  assign bufDrain   = bufDrainReq && (state_q == IDLE);

  dmem_store_buf #(
    .AW(AW),
    .DW(DW)
  ) u_store_buf (
    .clk_i      (clk),
    .rst_i      (reset),
    .capture_i  (bufCapture),
    .addr_i     (issueAddr),
    .wdata_i    (WriteDataM),
    .be_i       (byteEnable),
    .gnt_i      (bufDrain && mem_gnt),
    .full_o     (bufFull),
    .drain_req_o(bufDrainReq),
    .addr_o     (bufAddr),
    .wdata_o    (bufWdata),
    .be_o       (bufBe)
  );
`else
  assign bufCapture = 1'b0;
  assign bufFull    = 1'b0;
  assign bufDrain   = 1'b0;
  assign bufAddr    = '0;
  assign bufWdata   = '0;
  assign bufBe      = '0;
`endif

  assign issue = (state_q == IDLE) && access && !bufFull && !bufCapture;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      rdata_q <= rdata_d;
    end
  end

  // Request fields are latched at issue so REQ replays them unchanged.
  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (issue) begin
          we_d    = MemWriteM;
          addr_d  = issueAddr;
          wdata_d = WriteDataM;
          be_d    = byteEnable;
          if (mem_gnt) begin
            state_d = MemWriteM ? DONE : RESP;
          end else begin
            state_d = REQ;
          end
        end
      end
      REQ: begin
        if (mem_gnt) begin
          state_d = we_q ? DONE : RESP;
        end
      end
      RESP: begin
        if (mem_rvalid) begin
          rdata_d = mem_rdata;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    stallMem  = access && (state_q != DONE) && !bufCapture;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_be    = '0;
    case (state_q)
      IDLE: begin
        if (bufDrain) begin
          mem_req   = 1'b1;
          mem_we    = 1'b1;
          mem_addr  = bufAddr;
          mem_wdata = bufWdata;
          mem_be    = bufBe;
        end else if (issue) begin
          mem_req   = 1'b1;
          mem_we    = MemWriteM;
          mem_addr  = issueAddr;
          mem_wdata = WriteDataM;
          mem_be    = byteEnable;
        end
      end
      REQ: begin
        mem_req   = 1'b1;
        mem_we    = we_q;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        mem_be    = be_q;
      end
      default: begin
        mem_req = 1'b0;
      end
    endcase
  end

  assign ReadDataM = rdata_q;

endmodule
